// File: rtl/hex_disp_reader.sv
// Recovers per-digit 4-bit symbol codes from a multiplexed active-low 7-segment bus.
// Each (pattern, digit) pair must hold for STABLE_CYCLES samples before it is captured once.
module hex_disp_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] codes,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic                    frame_done
);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [7:0] STABLE_LEN = 8'(STABLE_CYCLES);

  // Returns {err, code}; an unrecognised pattern decodes as blank with err set.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0001100: decode = 5'h0B;
      7'b0111001: decode = 5'h0C;
      7'b0001111: decode = 5'h0D;
      7'b0111111: decode = 5'h0E;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1F;
    endcase
  endfunction

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [7:0]            run_len;
  state_t                state;

  logic       legal_in;
  logic       same_pair;
  logic [7:0] run_next;
  logic       capture;
  logic [3:0] dec_code;
  logic       dec_err;
  logic       cap_update;
  logic       cap_frame;

  // The run counter tracks the sample being registered this edge, so it is
  // compared against the pair currently held in s_seg/s_sel.
  assign legal_in  = $onehot(dig_sel);
  assign same_pair = (seg_in == s_seg) && (dig_sel == s_sel);
  assign run_next  = !legal_in ? 8'd0 :
                     !same_pair ? 8'd1 :
                     (run_len == 8'hFF) ? run_len : run_len + 8'd1;
  assign capture   = (state == ACQUIRE) && (run_len == STABLE_LEN);
  assign {dec_err, dec_code} = decode(s_seg);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    cap_update = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_sel[i] && (!valid[i] || codes[4*i +: 4] != dec_code || err[i] != dec_err))
        cap_update = 1'b1;
    end
    cap_frame = (&(valid | s_sel)) && !(&valid);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg      <= 7'h7F;
      s_sel      <= '0;
      run_len    <= 8'd0;
      state      <= ACQUIRE;
      codes      <= '1;
      valid      <= '0;
      err        <= '0;
      update     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s_seg      <= seg_in;
      s_sel      <= dig_sel;
      update     <= 1'b0;
      frame_done <= 1'b0;
      if (clr) begin
        run_len <= 8'd0;
        state   <= ACQUIRE;
        codes   <= '1;
        valid   <= '0;
        err     <= '0;
      end else begin
        run_len <= run_next;
        case (state)
          ACQUIRE: begin
            if (capture) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_sel[i]) begin
                  codes[4*i +: 4] <= dec_code;
                  err[i]          <= dec_err;
                  valid[i]        <= 1'b1;
                end
              end
              update     <= cap_update;
              frame_done <= cap_frame;
              // A pair that changes on the capture edge starts a fresh run.
              state      <= (legal_in && same_pair) ? LOCKED : ACQUIRE;
            end
          end
          LOCKED: begin
            if (!(legal_in && same_pair))
              state <= ACQUIRE;
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: doc/hex_disp_reader.md
# hex_disp_reader

Recovers per-digit 4-bit symbol codes from a multiplexed, active-low 7-segment display bus, the inverse of the team's 4-bit-to-7-segment digit encoder. It samples the segment lines and digit selects every clock, requires each (pattern, digit) pair to hold for a programmable number of cycles, decodes the pattern against the team's 16-symbol glyph set and stores the result per digit. It sits on the loop-back and self-test path between the display driver outputs and the checker and status logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before capture (1..255)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- seg_in  in  7  segment lines, active-low, bit0=a … bit6=g
- dig_sel  in  NUM_DIGITS  digit select, one-hot active-high; zero-hot or multi-hot means no digit is selected
- clr  in  1  synchronous clear of all captured state (valid, err, codes)
- codes  out  4*NUM_DIGITS  decoded code, digit i at [4i+3:4i]
- valid  out  NUM_DIGITS  digit i has been captured since the last rst/clr
- err  out  NUM_DIGITS  the last capture of digit i was an unrecognised pattern
- update  out  1  one-cycle pulse: a stored code or err bit changed, or a digit became valid
- frame_done  out  1  one-cycle pulse when valid first becomes all-ones after rst/clr

## Operation
- Input stage: s_seg and s_sel register seg_in and dig_sel on every edge.
- Run counter L (8 bits, saturating): if s_sel is not one-hot, L=0. Else, if (s_seg, s_sel) equals the previous registered pair, L=L+1. Otherwise L=1.
- FSM, two states:
  - ACQUIRE: when L reaches STABLE_CYCLES, capture once and go to LOCKED.
  - LOCKED: no further captures. Any change of the pair, or an illegal s_sel, returns the FSM to ACQUIRE.
- Decode is an exact match on s_seg (bits g..a). Listed as pattern→code:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0001100→B ("P")
  - 0111001→C, 0001111→D, 0111111→E, 1111111→F (blank)
- Any other pattern: code F and err=1. A recognised pattern gives err=0.
- A capture for digit i (the one-hot index of s_sel) writes codes[i] and err[i] and sets valid[i].
- update=1 if valid[i] was 0, or if the new code or err differs from the stored value.
- frame_done=1 when this capture makes valid all-ones and it was not all-ones before.
- clr: codes all F, valid=0, err=0, L=0, FSM to ACQUIRE. update and frame_done are not asserted.

## Timing
- Reset values: codes all 4'hF, valid 0, err 0, update 0, frame_done 0, L=0, FSM ACQUIRE, s_seg 7'h7F, s_sel 0.
- Latency: let the pair first be sampled on edge t (held from before t). Then L=STABLE_CYCLES after edge t+STABLE_CYCLES-1. Capture results (codes, valid, err, update, frame_done) are visible after edge t+STABLE_CYCLES.
- With STABLE_CYCLES=1, outputs are visible after edge t+1.
- update and frame_done are registered and high for exactly one cycle, coincident with the new codes.
- A pair that holds for STABLE_CYCLES-1 cycles and then changes produces no capture.
- A pair that holds indefinitely produces exactly one capture.
- Same pattern leaving and returning (A→B→A, each stable): each return is a new capture. update fires only if the stored value changes.
- clr in the same cycle as a capture: clr wins, the capture is discarded and the FSM goes to ACQUIRE.
- rst overrides clr and capture.
- L saturates at 255 and never wraps to 0.
- Illegal dig_sel (zero or multi-hot) in mid-run: L=0 and no capture. The next legal sample starts a new run with L=1.

## Test plan
- Reset, then digit 0 held at 1111001 for 4 cycles → after edge t+4: codes[3:0]=1, valid=0001, update pulse, err=0.
- Sweep all 16 glyphs on digit 2 (each held 6 cycles) → codes[11:8] follows 0..F, err stays 0, one update per glyph.
- Pattern 1010101 on digit 1 → codes[7:4]=F, err[1]=1. Then 1111111 → code F, err[1]=0, update pulse.
- Glitch: pair held 3 cycles then changed (STABLE_CYCLES=4) → no capture. dig_sel=0011 for 10 cycles → no capture.
- Scan digits 0..3 with 5-cycle dwell → single frame_done pulse after the digit-3 capture. A second scan with identical glyphs → no update, no frame_done.
- clr asserted on the capture edge → valid=0, codes all F, no update pulse. Re-acquisition after clr behaves as after reset.
